// File: rtl/inport_wh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inport_wh_pkg
//  Description : Shared types, direction constants and the XY route helper
//                for the wormhole input port.
//  Revision    : 1.0 - initial release
// ============================================================================
package inport_wh_pkg;

    // Two-bit flit type field carried below the destination coordinates
    typedef enum logic [1:0] {
        FT_HEAD     = 2'b00,
        FT_BODY     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    // One-hot output directions
    localparam logic [4:0] DIR_N = 5'b00001;
    localparam logic [4:0] DIR_E = 5'b00010;
    localparam logic [4:0] DIR_S = 5'b00100;
    localparam logic [4:0] DIR_W = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    // Widest coordinate the route helper accepts
    localparam int COORD_MAX_W = 8;

    // Dimension-ordered routing: resolve X first, then Y, else eject locally.
    // Coordinates are zero-extended, so the 9-bit signed difference gives the
    // same sign as a COORD_W+1 bit difference would.
    function automatic logic [4:0] xy_route(
        input logic [COORD_MAX_W-1:0] x_dest,
        input logic [COORD_MAX_W-1:0] y_dest,
        input logic [COORD_MAX_W-1:0] x_cur,
        input logic [COORD_MAX_W-1:0] y_cur
    );
        logic signed [COORD_MAX_W:0] dx;
        logic signed [COORD_MAX_W:0] dy;
        dx = $signed({1'b0, x_dest}) - $signed({1'b0, x_cur});
        dy = $signed({1'b0, y_dest}) - $signed({1'b0, y_cur});
        if (dx > 9'sd0)      return DIR_E;
        else if (dx < 9'sd0) return DIR_W;
        else if (dy > 9'sd0) return DIR_N;
        else if (dy < 9'sd0) return DIR_S;
        else                 return DIR_L;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inport_wh_if.sv
`default_nettype none
// ============================================================================
//  Module      : inport_wh_if
//  Description : Link/crossbar/allocator bundle of one router input port.
//                slave = the input port itself, master = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inport_wh_if #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [FLIT_W-1:0] flit_in;
    logic              valid_in;
    logic [4:0]        downstream_ready;
    logic [4:0]        sa_grant;
    logic [FLIT_W-1:0] flit_out;
    logic              valid_out;
    logic              sa_request;
    logic [4:0]        outport;
    logic              credit_out;
    logic [OCC_W-1:0]  occupancy;
    logic              overflow_err;

    modport slave (
        input  flit_in, valid_in, downstream_ready, sa_grant,
        output flit_out, valid_out, sa_request, outport, credit_out,
               occupancy, overflow_err
    );

    modport master (
        output flit_in, valid_in, downstream_ready, sa_grant,
        input  flit_out, valid_out, sa_request, outport, credit_out,
               occupancy, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/inport_wh_flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inport_wh_flit_fifo
//  Description : Show-ahead flit FIFO. A push is accepted when not full, or
//                when full but popped in the same cycle. dout_o is the front
//                entry (zero while empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module inport_wh_flit_fifo #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    input  wire logic [FLIT_W-1:0]          din_i,
    output logic      [FLIT_W-1:0]          dout_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic      [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array: written on accepted push only, never reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers and fill count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/inport_wh.sv
`default_nettype none
// ============================================================================
//  Module      : inport_wh
//  Description : Wormhole router input port. Buffers flits, XY-routes head
//                flits, requests the switch allocator and holds the granted
//                output for the whole packet with per-flit flow control.
//                Optional macro INPORT_PKT_STATS_EN adds a 16-bit pkt_count
//                output counting packets forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module inport_wh
    import inport_wh_pkg::*;
#(
    parameter int         FLIT_W   = 64,
    parameter int         DEPTH    = 16,
    parameter int         COORD_W  = 2,
    parameter int         X_CUR    = 0,
    parameter int         Y_CUR    = 0,
    parameter logic [4:0] PORT_DIR = 5'b00001
) (
    input  wire logic      clk,
    input  wire logic      rst,
    inport_wh_if.slave     bus
`ifdef INPORT_PKT_STATS_EN
    ,
    output logic [15:0]    pkt_count
`endif
);
    localparam int X_MSB    = FLIT_W - 1;
    localparam int Y_MSB    = FLIT_W - 1 - COORD_W;
    localparam int TYPE_LSB = FLIT_W - 2*COORD_W - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_ARB   = 2'd2;
    localparam logic [1:0] ST_XMIT  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [4:0]             outport_q, outport_d;
    logic                   overflow_q;
    logic [FLIT_W-1:0]      front;
    logic                   full, empty;
    logic [$clog2(DEPTH):0] count;
    logic                   pop;
    logic                   valid_out;
    logic                   discard;
    logic                   sa_request;
    flit_type_e             front_type;
    flit_type_e             in_type;
    logic                   front_is_head, front_is_tail, in_is_head;
    logic                   granted, ds_ok;

    inport_wh_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_flit_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.valid_in),
        .pop_i   (pop),
        .din_i   (bus.flit_in),
        .dout_o  (front),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Flit type decode of the buffer front and of the incoming flit
    always_comb begin
        front_type    = flit_type_e'(front[TYPE_LSB +: 2]);
        in_type       = flit_type_e'(bus.flit_in[TYPE_LSB +: 2]);
        front_is_head = (front_type == FT_HEAD) || (front_type == FT_HEADTAIL);
        front_is_tail = (front_type == FT_TAIL) || (front_type == FT_HEADTAIL);
        in_is_head    = (in_type == FT_HEAD) || (in_type == FT_HEADTAIL);
        granted       = (bus.sa_grant == PORT_DIR);
        ds_ok         = |(outport_q & bus.downstream_ready);
    end

    // State, latched route and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            outport_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            outport_q <= outport_d;
            if (bus.valid_in && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Next-state and route latch. An empty IDLE port may go straight to ROUTE
    // on an incoming head, since that flit is at the front next cycle. On the
    // tail pop, a flit already queued or arriving now lets the next packet
    // be routed without passing through IDLE.
    always_comb begin
        state_d   = state_q;
        outport_d = outport_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (front_is_head) state_d = ST_ROUTE;
                end else if (bus.valid_in && in_is_head) begin
                    state_d = ST_ROUTE;
                end
            end
            ST_ROUTE: begin
                outport_d = xy_route(COORD_MAX_W'(front[X_MSB -: COORD_W]),
                                     COORD_MAX_W'(front[Y_MSB -: COORD_W]),
                                     COORD_MAX_W'(X_CUR),
                                     COORD_MAX_W'(Y_CUR));
                state_d   = ST_ARB;
            end
            ST_ARB: begin
                if (granted && ds_ok) state_d = ST_XMIT;
            end
            ST_XMIT: begin
                if (valid_out && front_is_tail) begin
                    state_d = ((count > ($clog2(DEPTH)+1)'(1)) || bus.valid_in)
                              ? ST_ROUTE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: crossbar transfer, error-flit discard, credit and request
    always_comb begin
        valid_out  = (state_q == ST_XMIT) && !empty && granted && ds_ok;
        discard    = (state_q == ST_IDLE) && !empty && !front_is_head;
        pop        = valid_out || discard;
        sa_request = (state_q == ST_ARB) || (state_q == ST_XMIT);
    end

    assign bus.flit_out     = front;
    assign bus.valid_out    = valid_out;
    assign bus.credit_out   = pop;
    assign bus.sa_request   = sa_request;
    assign bus.outport      = outport_q;
    assign bus.occupancy    = count;
    assign bus.overflow_err = overflow_q;

`ifdef INPORT_PKT_STATS_EN
    logic [15:0] pkt_count_q;

    // Packets forwarded; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            pkt_count_q <= '0;
        else if (valid_out && front_is_tail) pkt_count_q <= pkt_count_q + 16'd1;
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule
`default_nettype wire
